lcd_write_sched: RTL

//  Round-robin scheduler that shares one LCD_Driver write port among NREQ requesters.

---
 rtl/lcd_write_sched.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_write_sched.sv
// Purpose: round-robin arbiter that shares one LCD_Driver write port among NREQ requesters.
// Latency: req seen at edge k -> gnt in cycle k+1 -> drv_write in k+2 (k+3 with a line change).
// Backpressure: requesters hold req until gnt; driver completion via drv_done, bounded by TMO.
module lcd_write_sched #(
  parameter int NREQ  = 4,
  parameter int DW    = 18,
  parameter int DWELL = 16,
  parameter int TMO   = 1024,
  localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_line,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      drv_data,
  output logic               drv_line,
  output logic               drv_setLine,
  output logic               drv_write,
  input  logic               drv_done,
  output logic               busy,
  output logic [SW-1:0]      src,
  output logic               err_timeout
);

  // One shared counter serves both the completion timeout and the post-write dwell.
  localparam int CMAX = (DWELL > TMO) ? DWELL : TMO;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
  localparam logic [CW-1:0] HOLD_LAST = (DWELL == 0) ? '0 : CW'(DWELL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LINE,
    S_WRITE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     ptr;
  logic [SW-1:0]     src_q;
  logic [DW-1:0]     lat_data;
  logic              lat_line;
  logic              cur_line;
  logic [NREQ-1:0]   gnt_q;
  logic [CW-1:0]     cnt;
  logic              err_q;

  logic              win_vld;
  logic [SW-1:0]     win_idx;
  int                scan_idx;

  logic              do_grant;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              set_err;
  logic              gnt_pend;

  // The grant pulse occupies the first cycle of LINE/WRITE, so the strobe
  // of that state is deferred by one cycle and never overlaps gnt.
  assign gnt_pend    = |gnt_q;
  assign gnt         = gnt_q;
  assign drv_data    = lat_data;
  assign drv_line    = lat_line;
  assign src         = src_q;
  assign err_timeout = err_q;
  assign busy        = (state != S_IDLE);

  // Round-robin pick: first pending request scanning upward from ptr+1, wrapping.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = (int'(ptr) + i) % NREQ;
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx[SW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and driver strobes.
  always_comb begin
    state_nxt   = state;
    do_grant    = 1'b0;
    drv_setLine = 1'b0;
    drv_write   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    set_err     = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          do_grant  = 1'b1;
          state_nxt = (req_line[win_idx] != cur_line) ? S_LINE : S_WRITE;
        end
      end
      S_LINE: begin
        if (!gnt_pend) begin
          drv_setLine = 1'b1;
          state_nxt   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!gnt_pend) begin
          drv_write = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (drv_done) begin
          cnt_clr   = 1'b1;
          state_nxt = S_HOLD;
        end else if (cnt == TMO_LAST) begin
          set_err   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_HOLD: begin
        if (DWELL == 0 || cnt == HOLD_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant latch, line tracking, shared counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= SW'(NREQ - 1);
      src_q    <= '0;
      lat_data <= '0;
      lat_line <= 1'b0;
      cur_line <= 1'b0;
      gnt_q    <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      gnt_q <= '0;
      if (do_grant) begin
        ptr      <= win_idx;
        src_q    <= win_idx;
        lat_data <= req_data[win_idx*DW +: DW];
        lat_line <= req_line[win_idx];
        gnt_q    <= NREQ'(1) << win_idx;
      end
      if (drv_setLine) begin
        cur_line <= lat_line;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
